// File: rtl/panel_scan_controller.sv
// Row-scan / bit-plane PWM sequencer for one panel_driver: fetch, brightness load,
// per-plane shift/latch/hold, then blank and advance to the next row.
module panel_scan_controller #(
    parameter int unsigned NUM_ROWS     = 16,
    parameter int unsigned LEDS_PER_ROW = 16,
    parameter int unsigned PWM_STEPS    = 256,
    parameter int unsigned FETCH_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    output logic                        shift,
    output logic                        load_led_vals,
    output logic                        load_brightness,
    output logic [7:0]                  pwm_time,
    output logic [$clog2(NUM_ROWS)-1:0] active_row_addr,
    output logic [NUM_ROWS-1:0]         row_enable_n,
    output logic                        frame_done,
    output logic                        busy
);

    localparam int unsigned ROW_W   = $clog2(NUM_ROWS);
    localparam int unsigned MAX_A   = (FETCH_CYCLES > LEDS_PER_ROW) ? FETCH_CYCLES : LEDS_PER_ROW;
    localparam int unsigned MAX_B   = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LOAD_BRT = 3'd2,
        SHIFT    = 3'd3,
        LATCH    = 3'd4,
        HOLD     = 3'd5,
        BLANK    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          pwm_q, pwm_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [NUM_ROWS-1:0] row_en_n_q, row_en_n_d;
    logic                shift_q, shift_d;
    logic                llv_q, llv_d;
    logic                lb_q, lb_d;
    logic                frame_done_q, frame_done_d;
    logic                busy_q, busy_d;
    logic                cnt_last;
    logic                do_step;

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pwm_d        = pwm_q;
        row_d        = row_q;
        row_en_n_d   = row_en_n_q;
        frame_done_d = 1'b0;
        do_step      = 1'b0;
        cnt_last     = (cnt_q == '0);

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = FETCH;
                    cnt_d   = CNT_W'(FETCH_CYCLES - 1);
                end
            end
            FETCH: begin
                if (cnt_last) state_d = LOAD_BRT;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            LOAD_BRT: begin
                state_d = SHIFT;
                cnt_d   = CNT_W'(LEDS_PER_ROW - 1);
                pwm_d   = 8'd0;
            end
            SHIFT: begin
                if (cnt_last) state_d = LATCH;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            LATCH: begin
                // Row turns on only after the first plane has been latched
                if (pwm_q == 8'd0) row_en_n_d = ~(NUM_ROWS'(1) << row_q);
                if (HOLD_CYCLES != 0) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    do_step = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_last) do_step = 1'b1;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            BLANK: begin
                if (cnt_last) begin
                    pwm_d = 8'd0;
                    if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                    state_d = enable ? FETCH : IDLE;
                    cnt_d   = CNT_W'(FETCH_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_step) begin
            if (pwm_q == 8'(PWM_STEPS - 1)) begin
                state_d = BLANK;
                cnt_d   = CNT_W'(BLANK_CYCLES - 1);
            end else begin
                state_d = SHIFT;
                cnt_d   = CNT_W'(LEDS_PER_ROW - 1);
                pwm_d   = pwm_q + 8'd1;
            end
        end

        if (state_d == BLANK || state_d == IDLE) row_en_n_d = '1;

        shift_d = (state_d == SHIFT);
        llv_d   = (state_d == LATCH);
        lb_d    = (state_d == LOAD_BRT);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pwm_q        <= 8'd0;
            row_q        <= '0;
            row_en_n_q   <= '1;
            shift_q      <= 1'b0;
            llv_q        <= 1'b0;
            lb_q         <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pwm_q        <= pwm_d;
            row_q        <= row_d;
            row_en_n_q   <= row_en_n_d;
            shift_q      <= shift_d;
            llv_q        <= llv_d;
            lb_q         <= lb_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign shift           = shift_q;
    assign load_led_vals   = llv_q;
    assign load_brightness = lb_q;
    assign pwm_time        = pwm_q;
    assign active_row_addr = row_q;
    assign row_enable_n    = row_en_n_q;
    assign frame_done      = frame_done_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_panel_scan_controller.sv
// Directed bench for panel_scan_controller: default build, a HOLD_CYCLES=0 build
// and a shrunken build used to walk a whole frame quickly.
module tb_panel_scan_controller;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // default build
    logic en_m, sh_m, llv_m, lb_m, fd_m, busy_m;
    logic [7:0]  pwm_m;
    logic [3:0]  row_m;
    logic [15:0] ren_m;

    // HOLD_CYCLES = 0 build
    logic en_h, sh_h, llv_h, lb_h, fd_h, busy_h;
    logic [7:0]  pwm_h;
    logic [3:0]  row_h;
    logic [15:0] ren_h;

    // small build: row period 11 cycles, frame 176 cycles
    logic en_s, sh_s, llv_s, lb_s, fd_s, busy_s;
    logic [7:0]  pwm_s;
    logic [3:0]  row_s;
    logic [15:0] ren_s;

    panel_scan_controller dut_m (
        .clk(clk), .reset_n(reset_n), .enable(en_m), .shift(sh_m),
        .load_led_vals(llv_m), .load_brightness(lb_m), .pwm_time(pwm_m),
        .active_row_addr(row_m), .row_enable_n(ren_m), .frame_done(fd_m), .busy(busy_m)
    );

    panel_scan_controller #(.HOLD_CYCLES(0)) dut_h (
        .clk(clk), .reset_n(reset_n), .enable(en_h), .shift(sh_h),
        .load_led_vals(llv_h), .load_brightness(lb_h), .pwm_time(pwm_h),
        .active_row_addr(row_h), .row_enable_n(ren_h), .frame_done(fd_h), .busy(busy_h)
    );

    panel_scan_controller #(.LEDS_PER_ROW(2), .PWM_STEPS(2), .FETCH_CYCLES(1),
                            .HOLD_CYCLES(1), .BLANK_CYCLES(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .enable(en_s), .shift(sh_s),
        .load_led_vals(llv_s), .load_brightness(lb_s), .pwm_time(pwm_s),
        .active_row_addr(row_s), .row_enable_n(ren_s), .frame_done(fd_s), .busy(busy_s)
    );

    // Background invariant tallies on the default build
    int mutex_bad = 0;
    int onehot_bad = 0;
    int rowsel_bad = 0;
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if ((32'(sh_m) + 32'(llv_m) + 32'(lb_m)) > 1) mutex_bad++;
            if ($countones(~ren_m) > 1) onehot_bad++;
            if (ren_m !== 16'hFFFF && ren_m !== ~(16'd1 << row_m)) rowsel_bad++;
        end
    end

    task automatic test_reset;
        int bad = 0;
        reset_n = 1'b0; en_m = 1'b0; en_h = 1'b0; en_s = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (sh_m !== 1'b0 || busy_m !== 1'b0 || ren_m !== 16'hFFFF)
            begin fails++; $display("FAIL in_reset: shift=%b busy=%b ren=%h expected 0 0 ffff", sh_m, busy_m, ren_m); end
        reset_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (sh_m !== 1'b0 || llv_m !== 1'b0 || lb_m !== 1'b0 || busy_m !== 1'b0 || fd_m !== 1'b0 ||
                pwm_m !== 8'd0 || row_m !== 4'd0 || ren_m !== 16'hFFFF) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL idle_100: %0d bad cycles, expected 0", bad); end
        tests++;
        if (ren_m !== 16'hFFFF) begin fails++; $display("FAIL idle_rows: ren=%h expected ffff", ren_m); end
        tests++;
        if (busy_h !== 1'b0 || busy_s !== 1'b0)
            begin fails++; $display("FAIL idle_others: busy_h=%b busy_s=%b expected 0 0", busy_h, busy_s); end
    endtask

    task automatic test_hold0;
        int nllv = 0;
        en_h = 1'b1;
        for (int k = 1; k <= 4364; k++) begin
            @(negedge clk);
            if (k <= 4363) nllv += 32'(llv_h);
            if (k == 20) begin
                tests++;
                if (llv_h !== 1'b1) begin fails++; $display("FAIL h0_latch: llv=%b expected 1", llv_h); end
            end
            if (k == 21) begin
                tests++;
                if (sh_h !== 1'b1 || pwm_h !== 8'd1)
                    begin fails++; $display("FAIL h0_no_hold: shift=%b pwm=%0d expected 1 1", sh_h, pwm_h); end
            end
            if (k == 4363) begin
                tests++;
                if (row_h !== 4'd0) begin fails++; $display("FAIL h0_row_end: row=%0d expected 0", row_h); end
            end
            if (k == 4364) begin
                tests++;
                if (row_h !== 4'd1) begin fails++; $display("FAIL h0_period: row=%0d expected 1", row_h); end
            end
        end
        en_h = 1'b0;
        tests++;
        if (nllv !== 256) begin fails++; $display("FAIL h0_latches: %0d expected 256", nllv); end
    endtask

    task automatic test_frame;
        int npulse = 0;
        int pulse_k = 0;
        logic [3:0] row_at_pulse = 4'hF;
        en_s = 1'b1;
        for (int k = 1; k <= 180; k++) begin
            @(negedge clk);
            if (fd_s === 1'b1) begin npulse++; pulse_k = k; row_at_pulse = row_s; end
            if (k == 2) begin
                tests++;
                if (lb_s !== 1'b1) begin fails++; $display("FAIL s_load_brt: lb=%b expected 1", lb_s); end
            end
            if (k == 176) begin
                tests++;
                if (row_s !== 4'd15) begin fails++; $display("FAIL s_last_row: row=%0d expected 15", row_s); end
            end
        end
        en_s = 1'b0;
        tests++;
        if (npulse !== 1) begin fails++; $display("FAIL frame_pulses: %0d expected 1", npulse); end
        tests++;
        if (pulse_k !== 177 || row_at_pulse !== 4'd0)
            begin fails++; $display("FAIL frame_wrap: cycle=%0d row=%0d expected 177 0", pulse_k, row_at_pulse); end
    endtask

    task automatic test_first_row;
        int nlb = 0, nsh = 0, nllv = 0, nfd = 0, off = 0, pwm_err = 0, latches = 0;
        int fetch_bad = 0, shrun_bad = 0, blank_bad = 0;
        en_m = 1'b1;
        for (int k = 1; k <= 5387; k++) begin
            @(negedge clk);
            if ((k == 1 || k == 2) && (busy_m !== 1'b1 || (sh_m | llv_m | lb_m) !== 1'b0)) fetch_bad++;
            if (k == 3) begin
                tests++;
                if (lb_m !== 1'b1 || pwm_m !== 8'd0)
                    begin fails++; $display("FAIL load_brt_t3: lb=%b pwm=%0d expected 1 0", lb_m, pwm_m); end
            end
            if (k >= 4 && k <= 19 && (sh_m !== 1'b1 || pwm_m !== 8'd0)) shrun_bad++;
            if (k == 20) begin
                tests++;
                if (llv_m !== 1'b1 || sh_m !== 1'b0 || ren_m !== 16'hFFFF)
                    begin fails++; $display("FAIL first_latch: llv=%b shift=%b ren=%h expected 1 0 ffff", llv_m, sh_m, ren_m); end
            end
            if (k == 21) begin
                tests++;
                if (ren_m !== 16'hFFFE) begin fails++; $display("FAIL row0_on: ren=%h expected fffe", ren_m); end
            end
            if (k >= 5380 && (ren_m !== 16'hFFFF || (sh_m | llv_m | lb_m) !== 1'b0 || busy_m !== 1'b1)) blank_bad++;
            nlb += 32'(lb_m); nsh += 32'(sh_m); nllv += 32'(llv_m); nfd += 32'(fd_m);
            if (sh_m === 1'b1 && pwm_m !== 8'(latches)) pwm_err++;
            if (llv_m === 1'b1) begin
                if (pwm_m !== 8'(latches)) pwm_err++;
                latches++;
            end
            if (ren_m === 16'hFFFF) off++;
            if (k == 5387) begin
                tests++;
                if (row_m !== 4'd0) begin fails++; $display("FAIL row_last_cycle: row=%0d expected 0", row_m); end
            end
        end
        tests++;
        if (fetch_bad !== 0) begin fails++; $display("FAIL fetch_2: %0d bad cycles expected 0", fetch_bad); end
        tests++;
        if (shrun_bad !== 0) begin fails++; $display("FAIL shift_run: %0d bad cycles expected 0", shrun_bad); end
        tests++;
        if (nlb !== 1 || nsh !== 4096 || nllv !== 256)
            begin fails++; $display("FAIL row_counts: lb=%0d shift=%0d llv=%0d expected 1 4096 256", nlb, nsh, nllv); end
        tests++;
        if (pwm_err !== 0) begin fails++; $display("FAIL pwm_seq: %0d errors expected 0", pwm_err); end
        tests++;
        if (blank_bad !== 0 || off !== 28)
            begin fails++; $display("FAIL blank: bad=%0d off=%0d expected 0 28", blank_bad, off); end
        tests++;
        if (nfd !== 0) begin fails++; $display("FAIL no_frame_done: %0d expected 0", nfd); end
        @(negedge clk);
        tests++;
        if (row_m !== 4'd1 || busy_m !== 1'b1)
            begin fails++; $display("FAIL row_advance: row=%0d busy=%b expected 1 1", row_m, busy_m); end
        repeat (20) @(negedge clk);
        tests++;
        if (ren_m !== 16'hFFFD) begin fails++; $display("FAIL row1_on: ren=%h expected fffd", ren_m); end
    endtask

    task automatic test_drop_enable;
        int guard = 0, nllv = 0, bad = 0;
        while (!(row_m === 4'd3 && pwm_m === 8'd100) && guard < 20000) begin @(negedge clk); guard++; end
        tests++;
        if (guard >= 20000) begin fails++; $display("FAIL reach_row3: timeout row=%0d pwm=%0d expected 3 100", row_m, pwm_m); end
        en_m = 1'b0;
        guard = 0;
        while (busy_m !== 1'b0 && guard < 6000) begin @(negedge clk); guard++; nllv += 32'(llv_m); end
        tests++;
        if (guard >= 6000) begin fails++; $display("FAIL drop_idle: timeout busy=%b expected 0", busy_m); end
        tests++;
        if (nllv !== 156) begin fails++; $display("FAIL drop_latches: %0d expected 156", nllv); end
        tests++;
        if (row_m !== 4'd4 || pwm_m !== 8'd0 || ren_m !== 16'hFFFF)
            begin fails++; $display("FAIL drop_park: row=%0d pwm=%0d ren=%h expected 4 0 ffff", row_m, pwm_m, ren_m); end
        repeat (50) begin
            @(negedge clk);
            if ((sh_m | llv_m | lb_m | busy_m) !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL parked_quiet: %0d bad cycles expected 0", bad); end
        en_m = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (lb_m !== 1'b1 || row_m !== 4'd4)
            begin fails++; $display("FAIL resume_row4: lb=%b row=%0d expected 1 4", lb_m, row_m); end
    endtask

    task automatic test_reset_mid_shift;
        int guard = 0;
        while (!(row_m === 4'd7 && pwm_m === 8'd5 && sh_m === 1'b1) && guard < 30000) begin @(negedge clk); guard++; end
        tests++;
        if (guard >= 30000 || ren_m !== 16'hFF7F)
            begin fails++; $display("FAIL reach_row7: guard=%0d ren=%h expected <30000 ff7f", guard, ren_m); end
        reset_n = 1'b0;
        #1;
        tests++;
        if (sh_m !== 1'b0 || ren_m !== 16'hFFFF || busy_m !== 1'b0 || row_m !== 4'd0 || pwm_m !== 8'd0)
            begin fails++; $display("FAIL async_reset: shift=%b ren=%h busy=%b row=%0d pwm=%0d expected 0 ffff 0 0 0",
                                    sh_m, ren_m, busy_m, row_m, pwm_m); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (lb_m !== 1'b1 || row_m !== 4'd0 || pwm_m !== 8'd0)
            begin fails++; $display("FAIL restart_row0: lb=%b row=%0d pwm=%0d expected 1 0 0", lb_m, row_m, pwm_m); end
    endtask

    task automatic test_invariants;
        tests++;
        if (mutex_bad !== 0) begin fails++; $display("FAIL strobe_mutex: %0d cycles expected 0", mutex_bad); end
        tests++;
        if (onehot_bad !== 0 || rowsel_bad !== 0)
            begin fails++; $display("FAIL row_onehot: multi=%0d wrong_row=%0d expected 0 0", onehot_bad, rowsel_bad); end
    endtask

    initial begin
        test_reset();
        test_hold0();
        test_frame();
        test_first_row();
        test_drop_enable();
        test_reset_mid_shift();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
